// File: rtl/chess_pkg.sv
// Shared types for the chess board user-interface blocks.
//   piece_code_t : 4-bit piece code as stored in the board array.
//                  0 = empty, bit COLOUR_BIT = colour (0 white, 1 black).
//   ptr_state_t  : pointer controller state (IDLE = nothing held, HELD = piece picked).
//   is_own_piece : true when a code is a non-empty piece of the given side.
package chess_pkg;

  typedef logic [3:0] piece_code_t;

  localparam piece_code_t EMPTY      = 4'd0;
  localparam int          COLOUR_BIT = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } ptr_state_t;

  function automatic logic is_own_piece(input piece_code_t piece, input logic side);
    return (piece != EMPTY) && (piece[COLOUR_BIT] == side);
  endfunction

endpackage

// File: rtl/board_hit_map.sv
// Registered pixel-to-square mapper.
//   clk, rst    : clock and synchronous active-high reset
//   xpos, ypos  : mouse coordinates (clk domain)
//   hover_valid : mouse lies inside the board (registered)
//   hover_pos   : row*BOARD_N + col under the mouse; holds its last value
//                 while the mouse is outside the board
module board_hit_map #(
  parameter  int BOARD_N  = 8,
  parameter  int SQ_LOG2  = 6,
  parameter  int ORIGIN_X = 256,
  parameter  int ORIGIN_Y = 128,
  parameter  int COORD_W  = 12,
  localparam int POS_W    = $clog2(BOARD_N * BOARD_N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] xpos,
  input  logic [COORD_W-1:0] ypos,
  output logic               hover_valid,
  output logic [POS_W-1:0]   hover_pos
);

  localparam logic signed [COORD_W:0] ORG_X = (COORD_W+1)'(ORIGIN_X);
  localparam logic signed [COORD_W:0] ORG_Y = (COORD_W+1)'(ORIGIN_Y);
  localparam logic signed [COORD_W:0] SPAN  = (COORD_W+1)'(BOARD_N << SQ_LOG2);
  localparam logic [POS_W-1:0]        ROW_K = POS_W'(BOARD_N);

  logic signed [COORD_W:0] dx, dy;
  logic                    in_x, in_y;
  logic [POS_W-1:0]        col, row;

  // One extra bit keeps the subtraction signed so a mouse left of / above the
  // origin shows up as a negative offset instead of wrapping.
  assign dx   = signed'({1'b0, xpos}) - ORG_X;
  assign dy   = signed'({1'b0, ypos}) - ORG_Y;
  assign in_x = !dx[COORD_W] && (dx < SPAN);
  assign in_y = !dy[COORD_W] && (dy < SPAN);
  assign col  = POS_W'(unsigned'(dx) >> SQ_LOG2);
  assign row  = POS_W'(unsigned'(dy) >> SQ_LOG2);

  // ---- stage p0: registered hover ----
  always_ff @(posedge clk) begin
    if (rst) begin
      hover_valid <= 1'b0;
      hover_pos   <= '0;
    end else begin
      hover_valid <= in_x && in_y;
      if (in_x && in_y) hover_pos <= row * ROW_K + col;
    end
  end

endmodule

// File: rtl/board_pointer_ctrl.sv
// Mouse pointer controller for the chess board.
// Maps the mouse to a hovered square, detects left-button clicks and runs the
// pick/place handshake toward the board state block.
//   clk, rst           : clk_65 pixel clock, synchronous active-high reset
//   lmb                : raw left mouse button (asynchronous)
//   xpos, ypos         : mouse coordinates (clk domain)
//   hover_piece        : piece code at hover_pos from the board array
//   move_mask          : legal targets for sel_pos, bit i = square i
//   hover_valid/pos    : hovered square
//   pick_piece, place_piece, cancel, illegal : mutually exclusive 1-cycle pulses
//   sel_pos, sel_valid : held piece square / piece held
//   target_pos         : destination, valid with place_piece
//   turn               : side to move (0 white)
module board_pointer_ctrl
  import chess_pkg::*;
#(
  parameter  int BOARD_N     = 8,
  parameter  int SQ_LOG2     = 6,
  parameter  int ORIGIN_X    = 256,
  parameter  int ORIGIN_Y    = 128,
  parameter  int COORD_W     = 12,
  parameter  int SYNC_STAGES = 2,
  parameter  int MASK_LAT    = 2,
  localparam int POS_W       = $clog2(BOARD_N * BOARD_N)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       lmb,
  input  logic [COORD_W-1:0]         xpos,
  input  logic [COORD_W-1:0]         ypos,
  input  logic [3:0]                 hover_piece,
  input  logic [BOARD_N*BOARD_N-1:0] move_mask,
  output logic                       hover_valid,
  output logic [POS_W-1:0]           hover_pos,
  output logic                       pick_piece,
  output logic                       place_piece,
  output logic                       cancel,
  output logic                       illegal,
  output logic [POS_W-1:0]           sel_pos,
  output logic [POS_W-1:0]           target_pos,
  output logic                       sel_valid,
  output logic                       turn
);

  localparam int               CNT_W  = $clog2(MASK_LAT + 2);
  localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(MASK_LAT);

  board_hit_map #(
    .BOARD_N (BOARD_N),
    .SQ_LOG2 (SQ_LOG2),
    .ORIGIN_X(ORIGIN_X),
    .ORIGIN_Y(ORIGIN_Y),
    .COORD_W (COORD_W)
  ) u_hit_map (
    .clk        (clk),
    .rst        (rst),
    .xpos       (xpos),
    .ypos       (ypos),
    .hover_valid(hover_valid),
    .hover_pos  (hover_pos)
  );

  logic [SYNC_STAGES-1:0] lmb_sync_p0;
  logic                   lmb_prev_p1;
  logic                   click_p1;

  // ---- stage p0/p1: button synchroniser, edge flop, registered click ----
  // Registering the click lines it up with the hover register, so the
  // decision below sees the square that was under the mouse when it fired.
  always_ff @(posedge clk) begin
    if (rst) begin
      lmb_sync_p0 <= '0;
      lmb_prev_p1 <= 1'b0;
      click_p1    <= 1'b0;
    end else begin
      lmb_sync_p0 <= {lmb_sync_p0[SYNC_STAGES-2:0], lmb};
      lmb_prev_p1 <= lmb_sync_p0[SYNC_STAGES-1];
      click_p1    <= lmb_sync_p0[SYNC_STAGES-1] & ~lmb_prev_p1;
    end
  end

  ptr_state_t       state_q, state_nx;
  logic [CNT_W-1:0] settle_q, settle_nx;
  logic [POS_W-1:0] sel_pos_nx, target_pos_nx;
  logic             sel_valid_nx, turn_nx;
  logic             pick_nx, place_nx, cancel_nx, illegal_nx;
  logic             own;

  assign own = is_own_piece(hover_piece, turn);

  always_comb begin
    state_nx      = state_q;
    settle_nx     = settle_q;
    sel_pos_nx    = sel_pos;
    target_pos_nx = target_pos;
    sel_valid_nx  = sel_valid;
    turn_nx       = turn;
    pick_nx       = 1'b0;
    place_nx      = 1'b0;
    cancel_nx     = 1'b0;
    illegal_nx    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (click_p1 && hover_valid && own) begin
          pick_nx      = 1'b1;
          sel_pos_nx   = hover_pos;
          sel_valid_nx = 1'b1;
          settle_nx    = LAT_LD;
          state_nx     = HELD;
        end
      end
      HELD: begin
        // The move mask lags a new selection; clicks are swallowed until it settles.
        if (settle_q != '0) begin
          settle_nx = settle_q - CNT_W'(1);
        end else if (click_p1) begin
          if (!hover_valid || hover_pos == sel_pos) begin
            cancel_nx    = 1'b1;
            sel_valid_nx = 1'b0;
            state_nx     = IDLE;
          end else if (own) begin
            pick_nx    = 1'b1;
            sel_pos_nx = hover_pos;
            settle_nx  = LAT_LD;
          end else if (move_mask[hover_pos]) begin
            place_nx      = 1'b1;
            target_pos_nx = hover_pos;
            sel_valid_nx  = 1'b0;
            turn_nx       = ~turn;
            state_nx      = IDLE;
          end else begin
            illegal_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---- stage p2: registered decision ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      settle_q    <= '0;
      sel_pos     <= '0;
      target_pos  <= '0;
      sel_valid   <= 1'b0;
      turn        <= 1'b0;
      pick_piece  <= 1'b0;
      place_piece <= 1'b0;
      cancel      <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      state_q     <= state_nx;
      settle_q    <= settle_nx;
      sel_pos     <= sel_pos_nx;
      target_pos  <= target_pos_nx;
      sel_valid   <= sel_valid_nx;
      turn        <= turn_nx;
      pick_piece  <= pick_nx;
      place_piece <= place_nx;
      cancel      <= cancel_nx;
      illegal     <= illegal_nx;
    end
  end

endmodule

// File: tb/tb_board_pointer_ctrl.sv
// Testbench for board_pointer_ctrl: directed scenarios followed by a random
// phase, every cycle compared against a behavioural model of the pointer.
module tb_board_pointer_ctrl;

  logic        clk = 1'b0;
  logic        rst, lmb;
  logic [11:0] xpos, ypos;
  logic [3:0]  hover_piece;
  logic [63:0] move_mask;
  logic        hover_valid, pick_piece, place_piece, cancel, illegal, sel_valid, turn;
  logic [5:0]  hover_pos, sel_pos, target_pos;

  board_pointer_ctrl dut (
    .clk(clk), .rst(rst), .lmb(lmb), .xpos(xpos), .ypos(ypos),
    .hover_piece(hover_piece), .move_mask(move_mask),
    .hover_valid(hover_valid), .hover_pos(hover_pos),
    .pick_piece(pick_piece), .place_piece(place_piece), .cancel(cancel), .illegal(illegal),
    .sel_pos(sel_pos), .target_pos(target_pos), .sel_valid(sel_valid), .turn(turn)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [3:0] bd [64];

  // Behavioural model state
  bit       m_hv, m_held, m_selv, m_turn, m_pick, m_place, m_cancel, m_ill;
  int       m_hp, m_cnt, m_sel, m_tgt;
  bit [3:0] m_lh;   // m_lh[0] = newest lmb sample

  task automatic model_edge();
    int dx, dy;
    bit clk_ev, own;
    dx = int'(xpos) - 256;
    dy = int'(ypos) - 128;
    m_pick = 0; m_place = 0; m_cancel = 0; m_ill = 0;
    if (rst) begin
      m_hv = 0; m_hp = 0; m_held = 0; m_selv = 0; m_turn = 0;
      m_cnt = 0; m_sel = 0; m_tgt = 0; m_lh = 0;
      return;
    end
    // A press sampled at edge k is acted on at edge k+3.
    clk_ev = m_lh[2] && !m_lh[3];
    own = (hover_piece != 4'd0) && (hover_piece[3] == m_turn);
    if (!m_held) begin
      if (clk_ev && m_hv && own) begin
        m_pick = 1; m_sel = m_hp; m_selv = 1; m_cnt = 2; m_held = 1;
      end
    end else if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
    end else if (clk_ev) begin
      if (!m_hv || m_hp == m_sel) begin
        m_cancel = 1; m_selv = 0; m_held = 0;
      end else if (own) begin
        m_pick = 1; m_sel = m_hp; m_cnt = 2;
      end else if (move_mask[m_hp]) begin
        m_place = 1; m_tgt = m_hp; m_selv = 0; m_turn = !m_turn; m_held = 0;
      end else begin
        m_ill = 1;
      end
    end
    if (dx >= 0 && dx < 512 && dy >= 0 && dy < 512) begin
      m_hv = 1;
      m_hp = (dy / 64) * 8 + dx / 64;
    end else begin
      m_hv = 0;
    end
    m_lh = {m_lh[2:0], lmb};
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [24:0] got, exp;
    @(posedge clk);
    model_edge();
    #1;
    got = {hover_valid, hover_pos, pick_piece, place_piece, cancel, illegal,
           sel_pos, target_pos, sel_valid, turn};
    exp = {m_hv, 6'(m_hp), m_pick, m_place, m_cancel, m_ill,
           6'(m_sel), 6'(m_tgt), m_selv, m_turn};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL cycle_model t=%0t: observed %h expected %h", $time, got, exp);
    end
    hover_piece = bd[m_hp];
  endtask

  function automatic logic [3:0] pulses();
    return {pick_piece, place_piece, cancel, illegal};
  endfunction

  function automatic logic [11:0] sq_x(input int c);
    return 12'(256 + c * 64 + 32);
  endfunction

  function automatic logic [11:0] sq_y(input int r);
    return 12'(128 + r * 64 + 32);
  endfunction

  // Move to (x,y), press, and report the pulses seen on the 4th cycle after the
  // rise plus whether any pulse appeared elsewhere in the press.
  task automatic press(input logic [11:0] x, input logic [11:0] y,
                       output logic [3:0] p4, output bit other);
    other = 0;
    xpos = x; ypos = y;
    step(); step();
    lmb = 1'b1;
    for (int i = 0; i < 3; i++) begin step(); other |= (pulses() != 4'd0); end
    step();
    p4 = pulses();
    lmb = 1'b0;
    for (int i = 0; i < 4; i++) begin step(); other |= (pulses() != 4'd0); end
  endtask

  logic [3:0] p;
  bit         oth;

  initial begin
    rst = 1'b1; lmb = 1'b0; xpos = '0; ypos = '0; move_mask = '0; hover_piece = '0;
    for (int i = 0; i < 64; i++) bd[i] = 4'd0;
    m_lh = 0;
    step(); step();
    chk("reset_outputs", {hover_valid, hover_pos, pulses(), sel_pos, target_pos, sel_valid, turn}, 0);
    rst = 1'b0;

    // Hover mapping
    xpos = 12'd300; ypos = 12'd140; step();
    chk("hover_valid_in", hover_valid, 1); chk("hover_pos_0", hover_pos, 0);
    xpos = 12'd255; step();
    chk("hover_valid_left", hover_valid, 0); chk("hover_pos_hold", hover_pos, 0);
    xpos = 12'd767; ypos = 12'd639; step();
    chk("hover_valid_corner", hover_valid, 1); chk("hover_pos_63", hover_pos, 63);

    // Pick white piece on 52, latency SYNC_STAGES+2
    bd[52] = 4'b0001; bd[51] = 4'b0010; bd[10] = 4'b1001;
    move_mask = '0; move_mask[36] = 1'b1;
    press(sq_x(4), sq_y(6), p, oth);
    chk("pick_pulse_at_4", p, 4'b1000); chk("pick_no_other", oth, 0);
    chk("pick_sel_pos", sel_pos, 52); chk("pick_sel_valid", sel_valid, 1);

    // Place on 36 and hold the button for 1000 cycles
    xpos = sq_x(4); ypos = sq_y(4); step(); step();
    lmb = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("place_pulse", pulses(), 4'b0100); chk("place_target", target_pos, 36);
    chk("place_turn", turn, 1); chk("place_sel_valid", sel_valid, 0);
    oth = 0;
    for (int i = 0; i < 1000; i++) begin step(); oth |= (pulses() != 4'd0); end
    chk("held_button_single_pulse", oth, 0);
    lmb = 1'b0; step(); step(); step();

    rst = 1'b1; step(); rst = 1'b0;
    chk("turn_after_reset", turn, 0);

    // Illegal then cancel
    press(sq_x(4), sq_y(6), p, oth);
    chk("repick_pulse", p, 4'b1000);
    press(sq_x(4), sq_y(2), p, oth);
    chk("illegal_pulse", p, 4'b0001); chk("illegal_still_held", sel_valid, 1);
    chk("illegal_sel_pos", sel_pos, 52);
    press(sq_x(4), sq_y(6), p, oth);
    chk("cancel_pulse", p, 4'b0010); chk("cancel_sel_valid", sel_valid, 0);

    // Reselect 51, then a second press inside the settle window
    press(sq_x(4), sq_y(6), p, oth);
    chk("pick_again", p, 4'b1000);
    xpos = sq_x(3); ypos = sq_y(6); step(); step();
    lmb = 1'b1; step(); lmb = 1'b0; step(); lmb = 1'b1; step(); step();
    chk("reselect_pulse", pulses(), 4'b1000); chk("reselect_sel_pos", sel_pos, 51);
    oth = 0;
    for (int i = 0; i < 3; i++) begin step(); oth |= (pulses() != 4'd0); end
    chk("settle_click_dropped", oth, 0);
    lmb = 1'b0; for (int i = 0; i < 4; i++) step();
    chk("settle_sel_pos_kept", sel_pos, 51);

    // Reset while held
    rst = 1'b1; step();
    chk("reset_while_held", {hover_valid, hover_pos, pulses(), sel_pos, target_pos, sel_valid, turn}, 0);
    rst = 1'b0;

    // Wrong colour and empty square in IDLE
    press(sq_x(2), sq_y(1), p, oth);
    chk("black_piece_no_pulse", {p, 3'b0, oth}, 0);
    press(sq_x(4), sq_y(2), p, oth);
    chk("empty_square_no_pulse", {p, 3'b0, oth}, 0);

    // Off-board click cancels a held piece
    press(sq_x(4), sq_y(6), p, oth);
    press(12'd100, 12'd100, p, oth);
    chk("offboard_cancel", p, 4'b0010);

    // Random phase
    for (int i = 0; i < 64; i++)
      bd[i] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    move_mask = {$urandom, $urandom};
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        xpos = 12'($urandom_range(200, 850));
        ypos = 12'($urandom_range(100, 700));
      end
      if ($urandom_range(0, 2) == 0) lmb = ~lmb;
      if ($urandom_range(0, 99) == 0) move_mask = {$urandom, $urandom};
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/board_pointer_ctrl.md
Name: board_pointer_ctrl

Overview:
- Parametrised successor of the single-board mouse click decoder.
- Converts the mouse position and left button into board-square hover information, then runs the pick/place move handshake toward the board state block.
- Adds capabilities the previous decoder lacks: configurable board geometry, turn ownership, legal-move gating against the move mask, reselect and cancel, and illegal-click reporting.
- Sits between the clk_65 mouse-position register stage and the board state / move logic blocks.

Parameters:
- BOARD_N, 8: squares per side. Range 2..16.
- SQ_LOG2, 6: log2 of the square edge in pixels (64 px).
- ORIGIN_X, 256: left pixel column of the board.
- ORIGIN_Y, 128: top pixel row of the board.
- COORD_W, 12: width of the mouse coordinates.
- SYNC_STAGES, 2: number of synchroniser flops on lmb. Minimum 2.
- MASK_LAT, 2: cycles after a pick during which clicks are ignored, while the move mask settles.
- POS_W, $clog2(BOARD_N*BOARD_N): square index width. Derived; do not override.

Ports:
- clk, in, 1: pixel clock (clk_65 domain).
- rst, in, 1: synchronous reset, active-high.
- lmb, in, 1: raw left mouse button. Asynchronous to clk.
- xpos, in, COORD_W: mouse x, already registered in the clk domain.
- ypos, in, COORD_W: mouse y, already registered in the clk domain.
- hover_piece, in, 4: piece code at hover_pos, combinational from the board array. 0 = empty; bit3 = colour (0 white, 1 black).
- move_mask, in, BOARD_N*BOARD_N: legal targets for sel_pos. Bit i is square i.
- hover_valid, out, 1: mouse is inside the board.
- hover_pos, out, POS_W: row*BOARD_N + col under the mouse.
- pick_piece, out, 1: 1-cycle pulse; a piece is selected.
- place_piece, out, 1: 1-cycle pulse; move to target_pos is committed.
- cancel, out, 1: 1-cycle pulse; selection dropped.
- illegal, out, 1: 1-cycle pulse; click on a non-legal square while HELD.
- sel_pos, out, POS_W: selected square.
- target_pos, out, POS_W: destination square. Valid when place_piece is high.
- sel_valid, out, 1: a piece is currently held.
- turn, out, 1: side to move. 0 = white.

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, synchroniser and edge flops cleared. Reset mid-operation drops any held piece with no cancel pulse.
- Hover, 1-cycle registered:
  - dx = xpos - ORIGIN_X, dy = ypos - ORIGIN_Y, computed at COORD_W+1 bits signed.
  - hover_valid = dx >= 0 and dx < BOARD_N<<SQ_LOG2, with the same test on dy.
  - col = dx>>SQ_LOG2, row = dy>>SQ_LOG2.
  - When not valid, hover_pos holds its last value.
- Click detection:
  - lmb passes through SYNC_STAGES flops.
  - click = rising edge of the synchronised signal: exactly one pulse per press; release is ignored.
- Decision timing:
  - The decision is registered one cycle after click, using hover_valid, hover_pos and hover_piece of the click cycle.
  - Pulse latency from the lmb rise is SYNC_STAGES+2 cycles.
  - At most one of pick_piece, place_piece, cancel, illegal is asserted in any cycle.
- FSM IDLE:
  - Click with hover_valid, hover_piece != 0 and hover_piece[3] == turn: pick_piece, sel_pos <= hover_pos, sel_valid <= 1, load settle counter with MASK_LAT, go to HELD.
  - Any other click: no output, stay in IDLE.
- FSM HELD:
  - While the settle counter is nonzero, it decrements and clicks are dropped silently.
  - Click not in board, or click on sel_pos: cancel, sel_valid <= 0, go to IDLE.
  - Click with hover_piece non-empty and own colour: reselect. Issue pick_piece, sel_pos <= hover_pos, reload the counter, stay in HELD.
  - Click with move_mask[hover_pos] == 1: place_piece, target_pos <= hover_pos, sel_valid <= 0, turn <= ~turn, go to IDLE.
  - Otherwise: illegal, stay in HELD.
- Priority within HELD: out-of-board / same square, then own piece, then legal mask, then illegal.
- turn changes only on place_piece.

Decomposition:
- Package chess_pkg holds:
  - piece_code_t (4-bit): EMPTY = 0, COLOUR_BIT = 3.
  - ptr_state_t enum: IDLE, HELD.
- Sub-module board_hit_map: registered pixel-to-square mapper with parameters BOARD_N, SQ_LOG2, ORIGIN_X, ORIGIN_Y, COORD_W; outputs hover_valid and hover_pos.
- The lmb synchroniser stays inline.

Test Plan:
- Reset, then mouse at (300,140) → hover_valid=1, hover_pos=0. Mouse at (255,140) → hover_valid=0. Mouse at (767,639) → hover_pos=63.
- turn=0; click on square 52 holding 4'b0001 → pick_piece exactly SYNC_STAGES+2 cycles after the lmb rise, sel_pos=52, sel_valid=1.
- HELD at 52 with move_mask bit 36 set; click on 36 → place_piece, target_pos=36, turn=1, sel_valid=0. Holding lmb high for 1000 cycles gives no second pulse.
- HELD at 52; click on 20 with mask bit clear → illegal, state stays HELD. Then click on 52 → cancel, IDLE.
- HELD at 52; click on own piece at 51 → pick_piece, sel_pos=51. A click issued within MASK_LAT cycles of that pick produces no pulse.
- turn=0; click on a black piece (4'b1001) or an empty square → no pulse. Assert rst while HELD → all outputs 0 on the next cycle.
